// File: rtl/ex_pipe.sv
// ex_pipe -- single-issue MIPS-style execute stage with a skid-free output
// register, an iterative shift-add multiplier and branch/load hazard counters.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (accept = in_valid & in_ready)
//   op, func                 MIPS opcode and SPECIAL function field
//   data_a, data_b           rs / rt operand values
//   imm                      extended immediate; imm[10:6] is the shift amount
//   npc, jpc                 PC+4 and the 26-bit J/JAL target field
//   rd_i, *_i controls       destination and control bits travelling with the op
//   out_valid / out_ready    downstream handshake on the output register
//   result, mem_data         ALU result or address, and store data
//   load_byte, rd_o, *_o     qualified control outputs
//   fwd_valid, ovf           forwardable result, signed-overflow pulse
//   pc_jump, pc_jumpto       combinational redirect in the accept cycle
//   bubble_cnt, flush_cnt    IF/ID stall and younger-instruction kill counts
//   busy                     multiplier running
module ex_pipe #(
  parameter int XLEN         = 32,
  parameter int MUL_BPC      = 1,
  parameter int LOAD_BUBBLES = 2,
  parameter int BRANCH_FLUSH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      op,
  input  logic [5:0]      func,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] npc,
  input  logic [25:0]     jpc,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] mem_data,
  output logic            load_byte,
  output logic [4:0]      rd_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            fwd_valid,
  output logic            ovf,
  output logic            pc_jump,
  output logic [XLEN-1:0] pc_jumpto,
  output logic [2:0]      bubble_cnt,
  output logic [2:0]      flush_cnt,
  output logic            busy
);

  localparam int MSB       = XLEN - 1;
  localparam int MUL_ITERS = XLEN / MUL_BPC;
  localparam int CW        = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);
  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_BUBBLES);
  localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_FLUSH);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_MUL     = 6'b011100;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_MUL  = 6'b000010;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mplier_q;
  logic [4:0]      mul_rd_q;
  logic            mul_rw_q;

  logic            out_valid_q, load_byte_q, rw_q, mr_q, mw_q, fwd_q, ovf_q;
  logic [XLEN-1:0] result_q, mem_data_q;
  logic [4:0]      rd_q;
  logic [2:0]      bubble_q, flush_q, bubble_dec, flush_dec;

  logic            out_free, accept, kill, mul_done;
  logic            known, is_mul, is_load, is_store, is_byte, taken, ovf_det;
  logic [XLEN-1:0] alu, target, sum, diff, addr, br_target, j_target;
  logic            rw_eff, mr_eff, mw_eff;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !rst && (state_q == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  // Any instruction arriving while the kill window is open is squashed.
  assign kill     = (flush_q != 3'd0);
  // The last multiplier step waits until the output register can take it.
  assign mul_done = (state_q == S_MUL) && (cnt_q == LAST) && out_free;

  assign sum       = data_a + data_b;
  assign diff      = data_a - data_b;
  assign addr      = data_a + imm;
  assign br_target = npc + (imm << 2);
  assign j_target  = {npc[XLEN-1:28], jpc, 2'b00};

  always_comb begin
    known    = 1'b1;
    is_mul   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    taken    = 1'b0;
    ovf_det  = 1'b0;
    target   = br_target;
    alu      = '0;
    case (op)
      OP_SPECIAL: begin
        case (func)
          F_ADD: begin
            alu     = sum;
            ovf_det = (data_a[MSB] == data_b[MSB]) && (sum[MSB] != data_a[MSB]);
          end
          F_ADDU: alu = sum;
          F_SUB: begin
            alu     = diff;
            ovf_det = (data_a[MSB] != data_b[MSB]) && (diff[MSB] != data_a[MSB]);
          end
          F_AND: alu = data_a & data_b;
          F_OR:  alu = data_a | data_b;
          F_XOR: alu = data_a ^ data_b;
          F_SLL: alu = data_b << imm[10:6];
          F_SRL: alu = data_b >> imm[10:6];
          F_JR: begin
            alu    = data_a;
            target = data_a;
            taken  = 1'b1;
          end
          default: known = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu     = addr;
        ovf_det = (data_a[MSB] == imm[MSB]) && (addr[MSB] != data_a[MSB]);
      end
      OP_ADDIU: alu = addr;
      OP_ANDI:  alu = data_a & imm;
      OP_ORI:   alu = data_a | imm;
      OP_XORI:  alu = data_a ^ imm;
      OP_LUI:   alu = imm << 16;
      OP_BEQ: begin
        alu   = br_target;
        taken = (data_a == data_b);
      end
      OP_BNE: begin
        alu   = br_target;
        taken = (data_a != data_b);
      end
      OP_BGTZ: begin
        alu   = br_target;
        taken = !data_a[MSB] && (data_a != '0);
      end
      OP_LW: begin alu = addr; is_load = 1'b1; end
      OP_LB: begin alu = addr; is_load = 1'b1; is_byte = 1'b1; end
      OP_SW: begin alu = addr; is_store = 1'b1; end
      OP_SB: begin alu = addr; is_store = 1'b1; is_byte = 1'b1; end
      OP_J: begin
        alu    = j_target;
        target = j_target;
        taken  = 1'b1;
      end
      OP_JAL: begin
        alu    = npc + XLEN'(4);
        target = j_target;
        taken  = 1'b1;
      end
      OP_MUL: begin
        if (func == F_MUL) is_mul = 1'b1;
        else               known  = 1'b0;
      end
      default: known = 1'b0;
    endcase
  end

  assign rw_eff = reg_write_i && known && !kill && !ovf_det;
  assign mr_eff = mem_read_i  && known && !kill;
  assign mw_eff = mem_write_i && known && !kill;

  assign pc_jump   = accept && taken && !kill;
  assign pc_jumpto = pc_jump ? target : '0;

  // Shift-add multiplier: MUL_BPC multiplier bits are consumed per cycle.
  logic [XLEN-1:0] pp [MUL_BPC];
  generate
    for (genvar gi = 0; gi < MUL_BPC; gi++) begin : g_pp
      assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
    end
  endgenerate

  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < MUL_BPC; k++) acc_d = acc_d + pp[k];
  end

  assign bubble_dec = (bubble_q == 3'd0) ? 3'd0 : bubble_q - 3'd1;
  assign flush_dec  = (flush_q  == 3'd0) ? 3'd0 : flush_q  - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mul_rd_q    <= '0;
      mul_rw_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      mem_data_q  <= '0;
      load_byte_q <= 1'b0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      fwd_q       <= 1'b0;
      ovf_q       <= 1'b0;
      bubble_q    <= '0;
      flush_q     <= '0;
    end else begin
      // ovf is a pulse aligned with the first cycle of the new result.
      ovf_q <= 1'b0;

      // Output register
      if (accept && !is_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= alu;
        mem_data_q  <= data_b;
        load_byte_q <= is_byte;
        rd_q        <= rd_i;
        rw_q        <= rw_eff;
        mr_q        <= mr_eff;
        mw_q        <= mw_eff;
        fwd_q       <= rw_eff && !is_load;
        ovf_q       <= ovf_det && !kill;
      end else if (mul_done) begin
        out_valid_q <= 1'b1;
        result_q    <= acc_d;
        mem_data_q  <= '0;
        load_byte_q <= 1'b0;
        rd_q        <= mul_rd_q;
        rw_q        <= mul_rw_q;
        mr_q        <= 1'b0;
        mw_q        <= 1'b0;
        fwd_q       <= mul_rw_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Multiplier sequencing
      if (accept && is_mul) begin
        state_q  <= S_MUL;
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= data_a;
        mplier_q <= data_b;
        mul_rd_q <= rd_i;
        mul_rw_q <= reg_write_i && !kill;
      end else if (mul_done) begin
        state_q <= S_IDLE;
      end else if (state_q == S_MUL && cnt_q != LAST) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << MUL_BPC;
        mplier_q <= mplier_q >> MUL_BPC;
        cnt_q    <= cnt_q + CW'(1);
      end

      // Hazard counters: only live instructions reload them.
      if (accept && !kill) begin
        flush_q  <= taken ? FLUSH_RELOAD : flush_dec;
        bubble_q <= is_load ? LOAD_RELOAD : (is_store ? 3'd1 : bubble_dec);
      end else begin
        flush_q  <= flush_dec;
        bubble_q <= bubble_dec;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign mem_data    = mem_data_q;
  assign load_byte   = load_byte_q;
  assign rd_o        = rd_q;
  assign reg_write_o = rw_q;
  assign mem_read_o  = mr_q;
  assign mem_write_o = mw_q;
  assign fwd_valid   = fwd_q;
  assign ovf         = ovf_q;
  assign bubble_cnt  = bubble_q;
  assign flush_cnt   = flush_q;
  assign busy        = (state_q == S_MUL);

endmodule

// File: tb/tb_ex_pipe.sv
// Directed bench for ex_pipe (XLEN=32, MUL_BPC=1). Expected output-register
// contents are queued when an instruction is issued and compared when the
// DUT hands the result downstream.
module tb_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  op, func;
  logic [31:0] data_a, data_b, imm, npc;
  logic [25:0] jpc;
  logic [4:0]  rd_i, rd_o;
  logic        reg_write_i, mem_read_i, mem_write_i;
  logic        out_valid, out_ready;
  logic [31:0] result, mem_data, pc_jumpto;
  logic        load_byte, reg_write_o, mem_read_o, mem_write_o;
  logic        fwd_valid, ovf, pc_jump, busy;
  logic [2:0]  bubble_cnt, flush_cnt;

  always #5 clk = ~clk;

  ex_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .func(func), .data_a(data_a), .data_b(data_b), .imm(imm),
    .npc(npc), .jpc(jpc), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .mem_data(mem_data), .load_byte(load_byte), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .fwd_valid(fwd_valid), .ovf(ovf),
    .pc_jump(pc_jump), .pc_jumpto(pc_jumpto), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt), .busy(busy)
  );

  localparam logic [5:0] SPC = 6'b000000, J = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGTZ = 6'b000111;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, LUI = 6'b001111;
  localparam logic [5:0] MULOP = 6'b011100, LB = 6'b100000, LW = 6'b100011;
  localparam logic [5:0] SB = 6'b101000, SW = 6'b101011;
  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_JR = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110;
  localparam logic [5:0] F_MUL = 6'b000010;

  // Packed layout: {pad6, result32, mem_data32, rd5, rw, mr, mw, fwd, lb}
  localparam logic [79:0] MD_BITS  = {38'b0, 32'hFFFF_FFFF, 10'b0};
  localparam logic [79:0] RES_BITS = {6'b0, 32'hFFFF_FFFF, 42'b0};
  localparam logic [79:0] M_ALL    = {80{1'b1}};
  localparam logic [79:0] M_STD    = ~MD_BITS;
  localparam logic [79:0] M_BR     = ~(MD_BITS | RES_BITS);

  int pass_cnt  = 0;
  int total_cnt = 0;
  int out_seen  = 0;
  logic [79:0] exp_q[$];
  logic [79:0] msk_q[$];
  logic [79:0] mon_e, mon_m;

  function automatic logic [79:0] pk(input logic [31:0] res, input logic [31:0] md,
                                     input logic [4:0] rd, input logic rw, input logic mr,
                                     input logic mw, input logic fwd, input logic lb);
    return {6'b0, res, md, rd, rw, mr, mw, fwd, lb};
  endfunction

  function automatic logic [79:0] alu_exp(input logic [31:0] res, input logic [4:0] rd,
                                          input logic rw);
    return pk(res, 32'h0, rd, rw, 1'b0, 1'b0, rw, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every handed-off result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 80'(out_valid), 80'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_m = msk_q.pop_front();
        chk($sformatf("out#%0d", out_seen),
            pk(result, mem_data, rd_o, reg_write_o, mem_read_o, mem_write_o,
               fwd_valid, load_byte) & mon_m,
            mon_e & mon_m);
        out_seen++;
      end
    end
  end

  // Presents one instruction; returns at the negedge of its accept cycle.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] np,
                       input logic [25:0] jt, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [79:0] e,
                       input logic [79:0] m);
    int w;
    @(posedge clk); #1;
    op = o; func = f; data_a = a; data_b = b; imm = im; npc = np; jpc = jt;
    rd_i = rd; reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 80'(in_ready), 80'd1);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic alu_op(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic [4:0] rd,
                        input logic [31:0] res, input logic rw_exp);
    issue(o, f, a, b, im, 32'h0, 26'h0, rd, 1'b1, 1'b0, 1'b0, alu_exp(res, rd, rw_exp), M_STD);
  endtask

  task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [4:0] rd);
    issue(MULOP, F_MUL, a, b, 32'h0, 32'h0, 26'h0, rd, 1'b1, 1'b0, 1'b0,
          alu_exp(res, rd, 1'b1), M_STD);
    idle(1);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk($sformatf("mul_busy[%0d]", c), 80'(busy), 80'd1);
      chk($sformatf("mul_in_ready[%0d]", c), 80'(in_ready), 80'd0);
    end
    @(negedge clk);
    chk("mul_busy_end", 80'(busy), 80'd0);
    chk("mul_out_valid", 80'(out_valid), 80'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; func = '0; data_a = '0; data_b = '0; imm = '0; npc = '0; jpc = '0;
    rd_i = '0; reg_write_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_bubble", 80'(bubble_cnt), 80'd0);
    chk("rst_flush", 80'(flush_cnt), 80'd0);
    chk("rst_result", 80'(result), 80'd0);
    chk("rst_rd_o", 80'(rd_o), 80'd0);
    chk("rst_pc_jump", 80'(pc_jump), 80'd0);
    chk("rst_reg_write", 80'(reg_write_o), 80'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Signed overflow on ADD
    alu_op(SPC, F_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd3, 32'h8000_0000, 1'b0);
    idle(1);
    @(negedge clk);
    chk("add_ovf_pulse", 80'(ovf), 80'd1);
    chk("add_ovf_valid", 80'(out_valid), 80'd1);
    chk("add_ovf_rw", 80'(reg_write_o), 80'd0);
    chk("add_ovf_result", 80'(result), 80'h8000_0000);
    @(negedge clk);
    chk("add_ovf_cleared", 80'(ovf), 80'd0);

    // Back-to-back ALU mix (drain and accept in the same cycle)
    alu_op(SPC, F_ADDU, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd4, 32'h1, 1'b1);
    alu_op(SPC, F_SUB, 32'h8000_0000, 32'h1, 32'h0, 5'd5, 32'h7FFF_FFFF, 1'b0);
    alu_op(SPC, F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'd6, 32'hF000_F000, 1'b1);
    alu_op(SPC, F_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'd6, 32'hFFF0_FFF0, 1'b1);
    alu_op(SPC, F_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'd6, 32'h0FF0_0FF0, 1'b1);
    alu_op(SPC, F_SLL, 32'h0, 32'h81, 32'h100, 5'd7, 32'h810, 1'b1);
    alu_op(SPC, F_SRL, 32'h0, 32'h8000_0000, 32'h7C0, 5'd7, 32'h1, 1'b1);
    alu_op(ADDI, 6'h0, 32'h10, 32'h0, 32'hFFFF_FFF0, 5'd8, 32'h0, 1'b1);
    alu_op(ADDIU, 6'h0, 32'h7FFF_FFFF, 32'h0, 32'h1, 5'd8, 32'h8000_0000, 1'b1);
    alu_op(ANDI, 6'h0, 32'hFFFF_1234, 32'h0, 32'h0000_FFFF, 5'd9, 32'h1234, 1'b1);
    alu_op(XORI, 6'h0, 32'h0000_FF00, 32'h0, 32'h0000_F0F0, 5'd9, 32'h0FF0, 1'b1);
    alu_op(LUI, 6'h0, 32'h0, 32'h0, 32'h1234, 5'd10, 32'h1234_0000, 1'b1);
    idle(1);

    // Taken BEQ kills the next two accepted instructions
    issue(BEQ, 6'h0, 32'h5, 32'h5, 32'h3, 32'h100, 26'h0, 5'd0, 1'b0, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0), M_BR);
    chk("beq_pc_jump", 80'(pc_jump), 80'd1);
    chk("beq_pc_jumpto", 80'(pc_jumpto), 80'h10C);
    issue(J, 6'h0, 32'h0, 32'h0, 32'h0, 32'h100, 26'h40, 5'd0, 1'b0, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0), M_BR);
    chk("flush_after_beq", 80'(flush_cnt), 80'd2);
    chk("killed_j_no_jump", 80'(pc_jump), 80'd0);
    issue(SPC, F_ADDU, 32'h1, 32'h2, 32'h0, 32'h0, 26'h0, 5'd7, 1'b1, 1'b0, 1'b0,
          alu_exp(32'h3, 5'd7, 1'b0), M_STD);
    chk("flush_second", 80'(flush_cnt), 80'd1);
    issue(SPC, F_ADDU, 32'h3, 32'h4, 32'h0, 32'h0, 26'h0, 5'd8, 1'b1, 1'b0, 1'b0,
          alu_exp(32'h7, 5'd8, 1'b1), M_STD);
    chk("flush_third", 80'(flush_cnt), 80'd0);
    idle(1);
    @(negedge clk);
    chk("flush_no_reload", 80'(flush_cnt), 80'd0);

    // Other jumps and branch conditions
    issue(JAL, 6'h0, 32'h0, 32'h0, 32'h0, 32'h1000_0004, 26'h40, 5'd31, 1'b1, 1'b0, 1'b0,
          alu_exp(32'h1000_0008, 5'd31, 1'b1), M_STD);
    chk("jal_pc_jump", 80'(pc_jump), 80'd1);
    chk("jal_pc_jumpto", 80'(pc_jumpto), 80'h1000_0100);
    idle(2);
    issue(SPC, F_JR, 32'h2468, 32'h0, 32'h0, 32'h0, 26'h0, 5'd0, 1'b0, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0), M_BR);
    chk("jr_pc_jumpto", 80'(pc_jumpto), 80'h2468);
    idle(2);
    issue(BNE, 6'h0, 32'h9, 32'h9, 32'h4, 32'h40, 26'h0, 5'd0, 1'b0, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0), M_BR);
    chk("bne_not_taken", 80'(pc_jump), 80'd0);
    issue(BGTZ, 6'h0, 32'hFFFF_FFFF, 32'h0, 32'h4, 32'h40, 26'h0, 5'd0, 1'b0, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0), M_BR);
    chk("bgtz_neg_not_taken", 80'(pc_jump), 80'd0);
    issue(BGTZ, 6'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h200, 26'h0, 5'd0, 1'b0, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0), M_BR);
    chk("bgtz_taken_target", 80'(pc_jumpto), 80'h1FC);
    idle(2);
    issue(BNE, 6'h0, 32'h1, 32'h2, 32'h0, 32'h40, 26'h0, 5'd0, 1'b0, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0), M_BR);
    chk("bne_taken_target", 80'(pc_jumpto), 80'h40);
    idle(2);

    // Stores and byte load
    issue(SW, 6'h0, 32'h100, 32'hDEAD_BEEF, 32'h8, 32'h0, 26'h0, 5'd0, 1'b0, 1'b0, 1'b1,
          pk(32'h108, 32'hDEAD_BEEF, 5'd0, 0, 0, 1, 0, 0), M_ALL);
    idle(1);
    @(negedge clk);
    chk("sw_bubble", 80'(bubble_cnt), 80'd1);
    issue(SB, 6'h0, 32'h200, 32'h55, 32'hFFFF_FFFF, 32'h0, 26'h0, 5'd0, 1'b0, 1'b0, 1'b1,
          pk(32'h1FF, 32'h55, 5'd0, 0, 0, 1, 0, 1), M_ALL);
    issue(LB, 6'h0, 32'h0, 32'h0, 32'h3, 32'h0, 26'h0, 5'd9, 1'b1, 1'b1, 1'b0,
          pk(32'h3, 32'h0, 5'd9, 1, 1, 0, 0, 1), M_STD);

    // LW held in the output register for three cycles
    issue(LW, 6'h0, 32'h1000, 32'h0, 32'h10, 32'h0, 26'h0, 5'd10, 1'b1, 1'b1, 1'b0,
          pk(32'h1010, 32'h0, 5'd10, 1, 1, 0, 0, 0), M_STD);
    @(posedge clk); #1;
    out_ready = 1'b0;
    op = ORI; func = 6'h0; data_a = 32'h1; imm = 32'h2; rd_i = 5'd11;
    reg_write_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lw_hold_valid[%0d]", k), 80'(out_valid), 80'd1);
      chk($sformatf("lw_hold_result[%0d]", k), 80'(result), 80'h1010);
      chk($sformatf("lw_hold_rd[%0d]", k), 80'(rd_o), 80'd10);
      chk($sformatf("lw_hold_in_ready[%0d]", k), 80'(in_ready), 80'd0);
      chk($sformatf("lw_bubble[%0d]", k), 80'(bubble_cnt), 80'(2 - k));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(alu_exp(32'h3, 5'd11, 1'b1));
    msk_q.push_back(M_STD);
    @(negedge clk);
    chk("drain_in_ready", 80'(in_ready), 80'd1);
    idle(1);
    @(negedge clk);
    chk("drain_accept_valid", 80'(out_valid), 80'd1);

    // Unknown encodings
    issue(6'b111111, 6'h0, 32'h1, 32'h2, 32'h3, 32'h0, 26'h0, 5'd12, 1'b1, 1'b1, 1'b1,
          pk(32'h0, 32'h0, 5'd12, 0, 0, 0, 0, 0), M_BR);
    chk("unknown_no_jump", 80'(pc_jump), 80'd0);
    issue(SPC, 6'b111111, 32'h1, 32'h2, 32'h0, 32'h0, 26'h0, 5'd12, 1'b1, 1'b0, 1'b0,
          pk(32'h0, 32'h0, 5'd12, 0, 0, 0, 0, 0), M_BR);
    idle(1);

    // Multiplier
    mul_run(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 5'd13);
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 5'd14);
    mul_run(32'h1234, 32'h100, 32'h12_3400, 5'd15);

    // Reset in the middle of a multiplication
    issue(MULOP, F_MUL, 32'h5, 32'h7, 32'h0, 32'h0, 26'h0, 5'd16, 1'b1, 1'b0, 1'b0,
          alu_exp(32'd35, 5'd16, 1'b1), M_STD);
    idle(1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midmul_rst_busy", 80'(busy), 80'd0);
    chk("midmul_rst_valid", 80'(out_valid), 80'd0);
    chk("midmul_rst_result", 80'(result), 80'd0);
    chk("midmul_rst_rw", 80'(reg_write_o), 80'd0);
    exp_q.delete();
    msk_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) chk($sformatf("post_rst_no_out[%0d]", c), 80'(out_valid), 80'd0);
    end
    chk("post_rst_idle", 80'(busy), 80'd0);
    alu_op(ORI, 6'h0, 32'h0F, 32'h0, 32'hF0, 5'd1, 32'hFF, 1'b1);
    idle(2);
    @(negedge clk);

    chk("scoreboard_empty", 80'(exp_q.size()), 80'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
